pi_loop_sequencer: RTL and testbench

PI_LOOP_SEQUENCER -- requirements
Module: pi_loop_sequencer

---
 rtl/pi_loop_sequencer.sv | 155 +++++++++++++++
 tb/tb_pi_loop_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_loop_sequencer.sv
// rtl/pi_loop_sequencer.sv - control-period sequencer feeding a PI speed controller
// Ramps the reference, freezes plant samples and swaps gains once per control period.
module pi_loop_sequencer #(
  parameter int PERIOD_MIN = 3
) (
  input  logic        i_clk,
  input  logic        i_n_reset,
  input  logic        i_run,
  input  logic [15:0] i_period,
  input  logic [11:0] i_target_ref,
  input  logic [7:0]  i_ramp_step,
  input  logic [7:0]  i_p_gain_wr,
  input  logic [7:0]  i_i_gain_wr,
  input  logic        i_gain_load,
  input  logic        i_plant_valid,
  input  logic [12:0] i_plant_speed,
  output logic        o_enable_control,
  output logic [7:0]  o_p_gain,
  output logic [7:0]  o_i_gain,
  output logic [11:0] o_reference,
  output logic [12:0] o_plant_output,
  output logic        o_gain_pending,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam logic [15:0] PMIN = 16'(PERIOD_MIN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [12:0] cap_q, cap_d;
  logic [12:0] plant_q, plant_d;
  logic [7:0]  p_gain_q, p_gain_d;
  logic [7:0]  i_gain_q, i_gain_d;
  logic [7:0]  stg_p_q, stg_p_d;
  logic [7:0]  stg_i_q, stg_i_d;
  logic        pend_q, pend_d;
  logic [11:0] ref_q, ref_d;

  logic [15:0] load_val;
  logic [11:0] ramp_diff, ramp_amt, ramp_ref, step_ext;
  logic        ramp_up;

  // WAIT spans load_val+1 cycles, SAMPLE and UPDATE one each: total = effective period.
  always_comb begin
    load_val = ((i_period < PMIN) ? PMIN : i_period) - 16'd3;
    step_ext = {4'd0, i_ramp_step};
    ramp_up  = i_target_ref > ref_q;
    ramp_diff = ramp_up ? (i_target_ref - ref_q) : (ref_q - i_target_ref);
    ramp_amt  = (step_ext < ramp_diff) ? step_ext : ramp_diff;
    ramp_ref  = ramp_up ? (ref_q + ramp_amt) : (ref_q - ramp_amt);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = i_plant_valid ? i_plant_speed : cap_q;
    plant_d  = plant_q;
    p_gain_d = p_gain_q;
    i_gain_d = i_gain_q;
    stg_p_d  = stg_p_q;
    stg_i_d  = stg_i_q;
    pend_d   = pend_q;
    ref_d    = ref_q;
    case (state_q)
      IDLE: begin
        if (i_run) begin
          state_d = WAIT;
          cnt_d   = load_val;
        end
      end
      WAIT: begin
        if (!i_run) begin
          state_d = IDLE;
          ref_d   = '0;
        end else if (cnt_q == 16'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SAMPLE: begin
        if (!i_run) begin
          state_d = IDLE;
          ref_d   = '0;
        end else begin
          state_d = UPDATE;
          plant_d = cap_q;
          ref_d   = ramp_ref;
          if (pend_q) begin
            p_gain_d = stg_p_q;
            i_gain_d = stg_i_q;
            pend_d   = 1'b0;
          end
        end
      end
      default: begin
        if (!i_run) begin
          state_d = IDLE;
          ref_d   = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = load_val;
        end
      end
    endcase
    // A load in the SAMPLE cycle re-arms pending after the old staged set was applied.
    if (i_gain_load) begin
      stg_p_d = i_p_gain_wr;
      stg_i_d = i_i_gain_wr;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      plant_q  <= '0;
      p_gain_q <= '0;
      i_gain_q <= '0;
      stg_p_q  <= '0;
      stg_i_q  <= '0;
      pend_q   <= 1'b0;
      ref_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      plant_q  <= plant_d;
      p_gain_q <= p_gain_d;
      i_gain_q <= i_gain_d;
      stg_p_q  <= stg_p_d;
      stg_i_q  <= stg_i_d;
      pend_q   <= pend_d;
      ref_q    <= ref_d;
    end
  end

  assign o_enable_control = (state_q == UPDATE);
  assign o_p_gain         = p_gain_q;
  assign o_i_gain         = i_gain_q;
  assign o_reference      = ref_q;
  assign o_plant_output   = plant_q;
  assign o_gain_pending   = pend_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// tb/tb_pi_loop_sequencer.sv - self-checking bench for pi_loop_sequencer
// Directed vector tables plus randomized run against a phase-based reference model.
module tb_pi_loop_sequencer;

  logic        i_clk = 1'b0;
  logic        i_n_reset;
  logic        i_run;
  logic [15:0] i_period;
  logic [11:0] i_target_ref;
  logic [7:0]  i_ramp_step;
  logic [7:0]  i_p_gain_wr;
  logic [7:0]  i_i_gain_wr;
  logic        i_gain_load;
  logic        i_plant_valid;
  logic [12:0] i_plant_speed;
  logic        o_enable_control;
  logic [7:0]  o_p_gain;
  logic [7:0]  o_i_gain;
  logic [11:0] o_reference;
  logic [12:0] o_plant_output;
  logic        o_gain_pending;
  logic [1:0]  o_state;

  pi_loop_sequencer #(.PERIOD_MIN(3)) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset), .i_run(i_run), .i_period(i_period),
    .i_target_ref(i_target_ref), .i_ramp_step(i_ramp_step),
    .i_p_gain_wr(i_p_gain_wr), .i_i_gain_wr(i_i_gain_wr), .i_gain_load(i_gain_load),
    .i_plant_valid(i_plant_valid), .i_plant_speed(i_plant_speed),
    .o_enable_control(o_enable_control), .o_p_gain(o_p_gain), .o_i_gain(o_i_gain),
    .o_reference(o_reference), .o_plant_output(o_plant_output),
    .o_gain_pending(o_gain_pending), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] period;
    int          spacing;
  } per_vec_t;

  typedef struct {
    logic [11:0] target;
    logic [7:0]  step;
    logic [11:0] ref_exp;
  } ramp_vec_t;

  per_vec_t  pv[6];
  ramp_vec_t rv[14];

  // Reference model: position inside the control period rather than a down-counter.
  int m_idle, m_phase, m_peff;
  int m_ref, m_plant, m_cap, m_pg, m_ig, m_stg_p, m_stg_i, m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_enable_control !== 1'b1 && n < limit);
    if (o_enable_control !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL pulse_timeout: no pulse within %0d cycles, expected one", n);
    end
  endtask

  task automatic stop_loop();
    i_run = 1'b0;
    tick();
    tick();
  endtask

  function automatic int m_state();
    if (m_idle != 0) return 0;
    if (m_phase < m_peff - 2) return 1;
    if (m_phase == m_peff - 2) return 2;
    return 3;
  endfunction

  function automatic int eff_period(input logic [15:0] p);
    return (int'(p) < 3) ? 3 : int'(p);
  endfunction

  task automatic model_edge();
    int st, d, stp;
    st  = m_state();
    stp = int'(i_ramp_step);
    if (st == 2 && i_run) begin
      m_plant = m_cap;
      if (m_pend != 0) begin
        m_pg = m_stg_p;
        m_ig = m_stg_i;
        m_pend = 0;
      end
      d = int'(i_target_ref) - m_ref;
      if (d > 0) m_ref = m_ref + ((d < stp) ? d : stp);
      else       m_ref = m_ref - ((-d < stp) ? -d : stp);
    end
    if (m_idle != 0) begin
      if (i_run) begin
        m_idle  = 0;
        m_phase = 0;
        m_peff  = eff_period(i_period);
      end
    end else if (!i_run) begin
      m_idle = 1;
      m_ref  = 0;
    end else begin
      m_phase++;
      if (m_phase == m_peff) begin
        m_phase = 0;
        m_peff  = eff_period(i_period);
      end
    end
    if (i_gain_load) begin
      m_stg_p = int'(i_p_gain_wr);
      m_stg_i = int'(i_i_gain_wr);
      m_pend  = 1;
    end
    if (i_plant_valid) m_cap = int'(i_plant_speed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    logic [63:0] exp_v, act_v;

    pv[0] = '{16'd10, 10};
    pv[1] = '{16'd1, 3};
    pv[2] = '{16'd0, 3};
    pv[3] = '{16'd3, 3};
    pv[4] = '{16'd4, 4};
    pv[5] = '{16'd7, 7};

    rv[0]  = '{12'd500, 8'd100, 12'd100};
    rv[1]  = '{12'd500, 8'd100, 12'd200};
    rv[2]  = '{12'd500, 8'd100, 12'd300};
    rv[3]  = '{12'd500, 8'd100, 12'd400};
    rv[4]  = '{12'd500, 8'd100, 12'd500};
    rv[5]  = '{12'd500, 8'd100, 12'd500};
    rv[6]  = '{12'd450, 8'd100, 12'd450};
    rv[7]  = '{12'd450, 8'd0,   12'd450};
    rv[8]  = '{12'd700, 8'd0,   12'd450};
    rv[9]  = '{12'd700, 8'd255, 12'd700};
    rv[10] = '{12'd0,   8'd200, 12'd500};
    rv[11] = '{12'd0,   8'd255, 12'd245};
    rv[12] = '{12'd0,   8'd255, 12'd0};
    rv[13] = '{12'd4095, 8'd255, 12'd255};

    i_n_reset = 1'b0; i_run = 1'b0; i_period = 16'd10; i_target_ref = '0;
    i_ramp_step = '0; i_p_gain_wr = '0; i_i_gain_wr = '0; i_gain_load = 1'b0;
    i_plant_valid = 1'b0; i_plant_speed = '0;
    tick();
    tick();
    check("reset_outputs", 64'({o_enable_control, o_state, o_reference, o_plant_output,
          o_p_gain, o_i_gain, o_gain_pending}), 64'd0);
    i_n_reset = 1'b1;
    tick();
    check("idle_after_reset", 64'(o_state), 64'd0);

    // Pulse spacing; first pulse also lands exactly one period after run.
    foreach (pv[i]) begin
      i_period = pv[i].period;
      i_run = 1'b1;
      wait_pulse(40, n);
      check("first_pulse", 64'(n), 64'(pv[i].spacing));
      tick();
      check("pulse_width", 64'(o_enable_control), 64'd0);
      wait_pulse(40, n);
      check("spacing", 64'(n + 1), 64'(pv[i].spacing));
      stop_loop();
    end

    i_period = 16'd10;
    i_run = 1'b1;
    wait_pulse(40, n);
    tick();
    i_period = 16'd4;
    wait_pulse(40, n);
    check("period_change_mid", 64'(n + 1), 64'd10);
    wait_pulse(40, n);
    check("period_change_next", 64'(n), 64'd4);
    stop_loop();

    i_period = 16'd4;
    foreach (rv[i]) begin
      i_target_ref = rv[i].target;
      i_ramp_step = rv[i].step;
      i_run = 1'b1;
      wait_pulse(20, n);
      check("ramp_ref", 64'(o_reference), 64'(rv[i].ref_exp));
      check("ramp_state", 64'(o_state), 64'd3);
    end
    stop_loop();

    i_period = 16'd10; i_target_ref = '0; i_ramp_step = '0;
    i_run = 1'b1;
    wait_pulse(40, n);
    tick(); tick();
    i_gain_load = 1'b1; i_p_gain_wr = 8'd7; i_i_gain_wr = 8'd100;
    tick();
    i_gain_load = 1'b0;
    check("gain_pending_set", 64'(o_gain_pending), 64'd1);
    check("gain_not_yet", 64'(o_i_gain), 64'd0);
    wait_pulse(40, n);
    check("gain_i_applied", 64'(o_i_gain), 64'd100);
    check("gain_p_applied", 64'(o_p_gain), 64'd7);
    check("gain_pending_clr", 64'(o_gain_pending), 64'd0);
    tick(); tick();
    i_gain_load = 1'b1; i_p_gain_wr = 8'd21; i_i_gain_wr = 8'd20;
    tick();
    i_gain_load = 1'b0;
    cnt = 0;
    while (o_state !== 2'd2 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("reach_sample", 64'(o_state), 64'd2);
    i_gain_load = 1'b1; i_p_gain_wr = 8'd56; i_i_gain_wr = 8'd55;
    tick();
    i_gain_load = 1'b0;
    check("coincide_old_applied", 64'(o_i_gain), 64'd20);
    check("coincide_pending", 64'(o_gain_pending), 64'd1);
    wait_pulse(40, n);
    check("coincide_new_i", 64'(o_i_gain), 64'd55);
    check("coincide_new_p", 64'(o_p_gain), 64'd56);
    check("coincide_pending_clr", 64'(o_gain_pending), 64'd0);

    tick();
    i_plant_valid = 1'b1; i_plant_speed = 13'd123;
    tick();
    i_plant_speed = 13'd456;
    tick();
    i_plant_valid = 1'b0;
    wait_pulse(40, n);
    check("plant_sample", 64'(o_plant_output), 64'd456);
    i_plant_valid = 1'b1; i_plant_speed = 13'd789;
    tick();
    i_plant_valid = 1'b0;
    check("plant_held", 64'(o_plant_output), 64'd456);

    i_target_ref = 12'd500; i_ramp_step = 8'd100;
    wait_pulse(40, n);
    check("pre_stop_ref", 64'(o_reference), 64'd100);
    tick(); tick();
    i_run = 1'b0;
    tick();
    check("stop_state", 64'(o_state), 64'd0);
    check("stop_ref", 64'(o_reference), 64'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (o_enable_control === 1'b1) cnt++;
    end
    check("stop_no_pulse", 64'(cnt), 64'd0);
    i_run = 1'b1;
    wait_pulse(40, n);
    check("restart_ref1", 64'(o_reference), 64'd100);
    wait_pulse(40, n);
    check("restart_ref2", 64'(o_reference), 64'd200);

    #2;
    i_n_reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({o_enable_control, o_reference, o_plant_output,
          o_p_gain, o_i_gain, o_gain_pending}), 64'd0);
    check("async_reset_state", 64'(o_state), 64'd0);
    @(negedge i_clk);
    i_run = 1'b0;
    i_n_reset = 1'b1;
    tick();

    m_idle = 1; m_phase = 0; m_peff = 3; m_ref = 0; m_plant = 0; m_cap = 0;
    m_pg = 0; m_ig = 0; m_stg_p = 0; m_stg_i = 0; m_pend = 0;
    for (int ep = 0; ep < 6; ep++) begin
      i_period = 16'($urandom_range(0, 9));
      for (int c = 0; c < 80; c++) begin
        i_run = (c < 70);
        if ($urandom_range(0, 15) == 0) i_period = 16'($urandom_range(0, 9));
        if ($urandom_range(0, 19) == 0 || c == 0) i_target_ref = 12'($urandom);
        if ($urandom_range(0, 9) == 0 || c == 0)
          i_ramp_step = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        i_plant_valid = ($urandom_range(0, 2) == 0);
        i_plant_speed = 13'($urandom);
        i_gain_load = ($urandom_range(0, 9) == 0);
        i_p_gain_wr = 8'($urandom);
        i_i_gain_wr = 8'($urandom);
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        exp_v = 64'({(m_state() == 3), 2'(m_state()), 12'(m_ref), 13'(m_plant),
                     8'(m_pg), 8'(m_ig), (m_pend != 0)});
        act_v = 64'({o_enable_control, o_state, o_reference, o_plant_output,
                     o_p_gain, o_i_gain, o_gain_pending});
        check("random_cycle", act_v, exp_v);
      end
    end
    i_gain_load = 1'b0;
    i_plant_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
